clock_enable_ctrl: RTL and testbench

CLOCK_ENABLE_CTRL -- requirements
Module: clock_enable_ctrl

---
 rtl/clock_enable_ctrl_pkg.sv | 14 +
 rtl/clock_enable_ctrl_divider.sv | 45 ++++
 rtl/clock_enable_ctrl.sv | 137 +++++++++++++
 tb/tb_clock_enable_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_ctrl_pkg.sv
// Shared definitions for the clock-enable controller: FSM encoding and default widths.
package clock_enable_ctrl_pkg;

    localparam int DIV_WIDTH_DEF  = 8;
    localparam int STEP_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ce_state_e;

endpackage

// File: rtl/clock_enable_ctrl_divider.sv
// Programmable divider: counts 0..period while enabled and flags the terminal count.
module clock_divider
    import clock_enable_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority, otherwise wrap at period while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (en) begin
            if (cnt_q == period) begin
                cnt_d = {WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & ~clear & (cnt_q == period);

endmodule

// File: rtl/clock_enable_ctrl.sv
// Run/step/halt controller issuing a divided, registered clock-enable and counting issued pulses.
module clock_enable_ctrl
    import clock_enable_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int STEP_WIDTH = STEP_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_req,
    input  logic                  step_req,
    input  logic [STEP_WIDTH-1:0] step_n,
    input  logic                  halt_req,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  clr_cnt,
    output logic                  cpu_ce,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycle_cnt
);

    ce_state_e             state_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [STEP_WIDTH-1:0] remaining_q;
    logic                  cpu_ce_q;
    logic                  done_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q;
    logic [CNT_WIDTH-1:0]  cycle_cnt_d;
    logic                  tick_s;
    logic                  div_clear_s;
    logic                  div_en_s;

    // Holding the divider cleared in IDLE makes every accepted command start from count 0.
    assign div_clear_s = (state_q == ST_IDLE);
    assign div_en_s    = (state_q != ST_IDLE);

    clock_divider #(
        .WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk    (clk),
        .rst    (rst),
        .clear  (div_clear_s),
        .en     (div_en_s),
        .period (div_q),
        .tick   (tick_s)
    );

    // Control FSM; halt wins over a tick, which also drops any enable due on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= {DIV_WIDTH{1'b0}};
            remaining_q <= {STEP_WIDTH{1'b0}};
            cpu_ce_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run_req) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        div_q   <= div;
                    end else if (step_req && (step_n != {STEP_WIDTH{1'b0}})) begin
                        state_q     <= ST_STEP;
                        busy_q      <= 1'b1;
                        div_q       <= div;
                        remaining_q <= step_n;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cpu_ce_q <= tick_s;
                    end
                end
                ST_STEP: begin
                    if (halt_req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_s) begin
                        cpu_ce_q    <= 1'b1;
                        remaining_q <= remaining_q - STEP_WIDTH'(1);
                        if (remaining_q == STEP_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_STEP;
                        end
                    end else begin
                        state_q <= ST_STEP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count each cycle in which the enable is high; clear wins over the increment.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (clr_cnt) begin
            cycle_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (cpu_ce_q) begin
            cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Pulse counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Randomized and directed bench for clock_enable_ctrl against a cycle-level behavioural model.
module tb_clock_enable_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, step_req, halt_req, clr_cnt;
    logic [15:0] step_n;
    logic [7:0]  div;
    logic        cpu_ce, busy, done;
    logic [31:0] cycle_cnt;
    logic        cpu_ce4, busy4, done4;
    logic [3:0]  cycle_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit          m_busy, m_step, m_ce, m_done;
    int          m_div, m_t, m_rem;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;

    always #5 clk = ~clk;

    clock_enable_ctrl u_dut (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .step_n(step_n),
        .halt_req(halt_req), .div(div), .clr_cnt(clr_cnt),
        .cpu_ce(cpu_ce), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
    );

    clock_enable_ctrl #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .step_n(step_n),
        .halt_req(halt_req), .div(div), .clr_cnt(clr_cnt),
        .cpu_ce(cpu_ce4), .busy(busy4), .done(done4), .cycle_cnt(cycle_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_step = 1'b0; m_ce = 1'b0; m_done = 1'b0;
        m_div = 0; m_t = 0; m_rem = 0; m_cnt = 32'd0; m_cnt4 = 4'd0;
    endtask

    // Enables fall on every (div+1)-th edge after acceptance; counts see the previous cycle's enable.
    task automatic model_edge();
        bit ce_prev;
        ce_prev = m_ce;
        m_ce = 1'b0;
        m_done = 1'b0;
        if (m_busy) begin
            if (halt_req) begin
                m_busy = 1'b0;
            end else begin
                m_t++;
                if (m_t % (m_div + 1) == 0) begin
                    m_ce = 1'b1;
                    if (m_step) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_done = 1'b1;
                            m_busy = 1'b0;
                        end
                    end
                end
            end
        end else if (run_req) begin
            m_busy = 1'b1; m_step = 1'b0; m_t = 0; m_div = int'(div);
        end else if (step_req && step_n != 16'd0) begin
            m_busy = 1'b1; m_step = 1'b1; m_t = 0; m_div = int'(div); m_rem = int'(step_n);
        end
        if (clr_cnt) begin
            m_cnt = 32'd0; m_cnt4 = 4'd0;
        end else if (ce_prev) begin
            m_cnt = m_cnt + 32'd1; m_cnt4 = m_cnt4 + 4'd1;
        end
    endtask

    task automatic check_all();
        check("cpu_ce", {31'd0, cpu_ce}, {31'd0, m_ce});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("cycle_cnt", cycle_cnt, m_cnt);
        check("cpu_ce_w4", {31'd0, cpu_ce4}, {31'd0, m_ce});
        check("done_w4", {31'd0, done4}, {31'd0, m_done});
        check("cycle_cnt_w4", {28'd0, cycle_cnt4}, {28'd0, m_cnt4});
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        int n_ce;
        int n_done;
        bit reached;
        rst = 1'b1;
        idle_inputs();
        step_n = 16'd0;
        div = 8'd0;
        model_reset();
        #12;
        check("reset_state", {28'd0, cpu_ce, done, busy, cpu_ce4}, 32'd0);
        check("reset_cnt", cycle_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step_cycle();

        // continuous run with div=0, then halt
        div = 8'd0; run_req = 1'b1;
        step_cycle();
        idle_inputs();
        repeat (10) step_cycle();
        halt_req = 1'b1;
        step_cycle();
        idle_inputs();
        check("run_halt_cnt", cycle_cnt, 32'd10);
        check("run_halt_ce", {31'd0, cpu_ce}, 32'd0);
        repeat (3) step_cycle();

        // bounded step of 3 with div=3
        clr_cnt = 1'b1;
        step_cycle();
        idle_inputs();
        div = 8'd3; step_n = 16'd3; step_req = 1'b1;
        step_cycle();
        idle_inputs();
        n_ce = 0; n_done = 0;
        for (int i = 1; i <= 14; i++) begin
            step_cycle();
            if (cpu_ce) n_ce++;
            if (done) begin
                n_done++;
                check("done_with_last_ce", {31'd0, cpu_ce}, 32'd1);
                check("done_cycle", i, 32'd12);
            end
        end
        check("step3_ce_count", n_ce, 32'd3);
        check("step3_done_count", n_done, 32'd1);
        check("step3_cnt", cycle_cnt, 32'd3);
        check("step3_busy_after", {31'd0, busy}, 32'd0);

        // step_n = 0 is ignored
        step_n = 16'd0; step_req = 1'b1;
        step_cycle();
        idle_inputs();
        repeat (5) step_cycle();

        // run beats step in the same cycle; later step while busy ignored
        div = 8'd1; step_n = 16'd2; run_req = 1'b1; step_req = 1'b1;
        step_cycle();
        idle_inputs();
        repeat (4) step_cycle();
        step_req = 1'b1; step_n = 16'd1;
        step_cycle();
        idle_inputs();
        repeat (6) step_cycle();
        check("run_still_busy", {31'd0, busy}, 32'd1);
        halt_req = 1'b1;
        step_cycle();
        idle_inputs();
        step_cycle();

        // reset in the middle of a step with 5 remaining
        div = 8'd1; step_n = 16'd9; step_req = 1'b1;
        step_cycle();
        idle_inputs();
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step_cycle();
            if (m_rem == 5) reached = 1'b1;
        end
        check("reach_rem5", {31'd0, reached}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midstep_rst_out", {28'd0, cpu_ce, done, busy, busy4}, 32'd0);
        check("midstep_rst_cnt", cycle_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step_cycle();

        // 4-bit counter wrap and clear coincident with an enable
        div = 8'd0; run_req = 1'b1;
        step_cycle();
        idle_inputs();
        repeat (20) step_cycle();
        clr_cnt = 1'b1;
        step_cycle();
        idle_inputs();
        check("clr_wins_cnt", cycle_cnt, 32'd0);
        check("clr_wins_cnt4", {28'd0, cycle_cnt4}, 32'd0);
        repeat (3) step_cycle();
        halt_req = 1'b1;
        step_cycle();
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            run_req  = ($urandom_range(0, 15) == 0);
            step_req = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 24) == 0);
            clr_cnt  = ($urandom_range(0, 39) == 0);
            step_n   = 16'($urandom_range(0, 5));
            div      = 8'($urandom_range(0, 3));
            step_cycle();
        end
        idle_inputs();
        repeat (4) step_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
